// File: rtl/tsp_pkg.sv
// Purpose: shared constants and types for the TSP solver display path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tsp_pkg;

   // Solver performance word width and number of decimal display digits.
   localparam int PERF_W      = 32;
   localparam int DISP_DIGITS = 6;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } bcd_state_t;

endpackage

// File: rtl/bcd_add3.sv
// Purpose: double-dabble digit correction, adds 3 to a BCD nibble that is 5 or more.
// Latency: combinational.
// Backpressure: none.
// Ports: i_nib  - accumulator nibble before correction (0..9)
//        o_nib  - corrected nibble (0..4 unchanged, 5..9 -> 8..C)
module bcd_add3
   import tsp_pkg::*;
(
   input  bcd_digit_t i_nib,
   output bcd_digit_t o_nib
);

   always_comb begin
      o_nib = i_nib;
      if (i_nib >= 4'd5) begin
         o_nib = i_nib + 4'd3;
      end
   end

endmodule

// File: rtl/perf_bcd_conv.sv
// Purpose: sequential double-dabble binary-to-BCD converter, saturating at 10^DIGITS-1.
// Latency: done pulses IN_W+1 cycles after the accepting edge; one result per IN_W+2 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
// Ports: clk/rst  - clock, synchronous active-high reset
//        start    - conversion request, bin captured when accepted
//        bin      - unsigned binary input
//        busy     - conversion in progress (SHIFT or DONE state)
//        done     - one-cycle pulse, digits/ovf updated
//        digits   - packed BCD result, [3:0] = ones; held between conversions
//        ovf      - last input was >= 10^DIGITS (digits forced to all nines)
module perf_bcd_conv
   import tsp_pkg::*;
#(
   parameter int IN_W   = PERF_W,
   parameter int DIGITS = DISP_DIGITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [IN_W-1:0]     bin,
   output logic                busy,
   output logic                done,
   output logic [DIGITS*4-1:0] digits,
   output logic                ovf
);

   localparam int CNT_W = $clog2(IN_W);
   localparam int ACC_W = DIGITS * 4;

   bcd_state_t       r_state;
   bcd_state_t       w_state_nxt;
   logic [IN_W-1:0]  r_shreg;
   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] w_acc_adj;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf_int;
   logic [ACC_W-1:0] r_digits;
   logic             r_ovf;
   logic             r_done;

   // Per-digit add-3 correction applied before every shift.
   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .i_nib (r_acc[g*4 +: 4]),
         .o_nib (w_acc_adj[g*4 +: 4])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = SHIFT;
         SHIFT:   if (r_cnt == '0) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shreg   <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_ovf_int <= 1'b0;
         r_digits  <= '0;
         r_ovf     <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_shreg   <= bin;
                  r_acc     <= '0;
                  r_ovf_int <= 1'b0;
                  r_cnt     <= CNT_W'(IN_W - 1);
               end
            end
            SHIFT: begin
               // The bit leaving the top corrected nibble means the running
               // value has reached 10^DIGITS; once set it stays set.
               r_acc     <= {w_acc_adj[ACC_W-2:0], r_shreg[IN_W-1]};
               r_shreg   <= {r_shreg[IN_W-2:0], 1'b0};
               r_ovf_int <= r_ovf_int | w_acc_adj[ACC_W-1];
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            DONE: begin
               r_digits <= r_ovf_int ? {DIGITS{4'h9}} : r_acc;
               r_ovf    <= r_ovf_int;
               r_done   <= 1'b1;
            end
            default: begin
               r_done <= 1'b0;
            end
         endcase
      end
   end

   assign busy   = (r_state != IDLE);
   assign done   = r_done;
   assign digits = r_digits;
   assign ovf    = r_ovf;

endmodule
